// File: rtl/data_memory_sized.sv
// Word-organised data RAM with byte/half/word access, sign/zero load extension,
// sticky alignment/range error flags and a sequential clear FSM after reset.
module data_memory_sized #(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned TEST_WORD      = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic        RE,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic        err_clr,
  output logic [31:0] RD,
  output logic        busy,
  output logic        misaligned,
  output logic        oob_err,
  output logic [15:0] Test_value
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state, state_next;
  logic [AW-1:0] clr_ptr, clr_ptr_next;
  logic [31:0]   ram [DEPTH];

  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          oob, mis, legal, ready, wr_en;
  logic [31:0]   word, wdata;
  logic [3:0]    wmask;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= CLEAR_ON_RESET ? CLEAR : READY;
      clr_ptr <= '0;
    end else begin
      state   <= state_next;
      clr_ptr <= clr_ptr_next;
    end
  end

  // Clear sweep: one word per cycle, READY after the top word is written
  always_comb begin
    state_next   = state;
    clr_ptr_next = clr_ptr;
    if (state == CLEAR) begin
      clr_ptr_next = clr_ptr + AW'(1);
      if (clr_ptr == AW'(DEPTH - 1)) state_next = READY;
    end
  end

  assign ready = (state == READY);
  assign busy  = (state == CLEAR);

  // Address decode and legality
  always_comb begin
    widx = A[AW+1:2];
    lane = A[1:0];
    oob  = |A[31:AW+2];
    case (size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = A[0];
      default: mis = |A[1:0];
    endcase
    legal = !oob && !mis;
    wr_en = rst && ready && WE && legal;
  end

  assign word   = ram[widx];
  assign byte_v = 8'(word >> {lane, 3'b000});
  assign half_v = A[1] ? word[31:16] : word[15:0];

  // Combinational load path; zero whenever the access is not a legal READY read
  always_comb begin
    RD = '0;
    if (rst && ready && legal) begin
      case (size)
        2'b00:   RD = sign_ext ? {{24{byte_v[7]}}, byte_v} : {24'd0, byte_v};
        2'b01:   RD = sign_ext ? {{16{half_v[15]}}, half_v} : {16'd0, half_v};
        default: RD = word;
      endcase
    end
  end

  // Store lane steering: replicate data, then mask the target lanes
  always_comb begin
    case (size)
      2'b00: begin
        wdata = {4{WD[7:0]}};
        wmask = 4'b0001 << lane;
      end
      2'b01: begin
        wdata = {2{WD[15:0]}};
        wmask = A[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wdata = WD;
        wmask = 4'b1111;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst && state == CLEAR) begin
      ram[clr_ptr] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) ram[widx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  // Sticky error flags; a new error on the same edge beats err_clr
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misaligned <= 1'b0;
      oob_err    <= 1'b0;
    end else begin
      if (ready && (WE || RE) && mis) misaligned <= 1'b1;
      else if (err_clr)               misaligned <= 1'b0;
      if (ready && (WE || RE) && oob) oob_err <= 1'b1;
      else if (err_clr)               oob_err <= 1'b0;
    end
  end

  assign Test_value = ram[AW'(TEST_WORD)][15:0];

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized (DEPTH=8): a byte-wise reference memory
// produces expected load data, queued at stimulus time and popped at sampling.
module tb_data_memory_sized;

  localparam int unsigned DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        WE = 1'b0, RE = 1'b0, sign_ext = 1'b0, err_clr = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] A = '0, WD = '0;
  logic [31:0] RD;
  logic        busy, misaligned, oob_err;
  logic [15:0] Test_value;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl [DEPTH];
  logic [31:0] e;

  data_memory_sized #(.DEPTH(DEPTH), .TEST_WORD(0), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst), .WE(WE), .RE(RE), .size(size), .sign_ext(sign_ext),
    .A(A), .WD(WD), .err_clr(err_clr), .RD(RD), .busy(busy),
    .misaligned(misaligned), .oob_err(oob_err), .Test_value(Test_value)
  );

  always #5 clk = ~clk;

  function automatic logic is_mis(input logic [31:0] a, input logic [1:0] sz);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return a[0];
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    logic [31:0] w;
    logic [7:0]  b;
    logic [15:0] h;
    if (a >= 4 * DEPTH || is_mis(a, sz)) return 32'd0;
    w = mdl[a[4:2]];
    b = w[8*a[1:0] +: 8];
    h = w[16*a[1] +: 16];
    case (sz)
      2'b00:   return sx ? {{24{b[7]}}, b} : {24'd0, b};
      2'b01:   return sx ? {{16{h[15]}}, h} : {16'd0, h};
      default: return w;
    endcase
  endfunction

  function automatic void mstore(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    if (a >= 4 * DEPTH || is_mis(a, sz)) return;
    case (sz)
      2'b00:   mdl[a[4:2]][8*a[1:0] +: 8] = wd[7:0];
      2'b01:   mdl[a[4:2]][16*a[1] +: 16] = wd[15:0];
      default: mdl[a[4:2]] = wd;
    endcase
  endfunction

  // Drive one access at the current (negedge) time and queue the expected RD
  task automatic drive(input logic we, input logic re, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] wd, input logic clr);
    WE = we; RE = re; size = sz; sign_ext = sx; A = a; WD = wd; err_clr = clr;
    exp_q.push_back(exp_load(a, sz, sx));
    #1;
  endtask

  // Commit the driven access on the next edge and return to idle at the negedge
  task automatic cycle();
    @(posedge clk);
    if (WE) mstore(A, size, WD);
    @(negedge clk);
    WE = 1'b0; RE = 1'b0; err_clr = 1'b0;
  endtask

  task automatic test_reset();
    int cnt;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0);
    e = exp_q.pop_front(); e = 32'd0;
    checks++; if (RD !== e) begin failures++; $display("FAIL reset_rd: got %h want %h", RD, e); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b want 1", busy); end
    checks++; if ({misaligned, oob_err} !== 2'b00) begin failures++; $display("FAIL reset_flags: got %b want 00", {misaligned, oob_err}); end
    WE = 1'b1; RE = 1'b0; A = 32'h0; WD = 32'hFFFF_FFFF;
    rst = 1'b1;
    cnt = 0;
    while (busy && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    WE = 1'b0;
    checks++; if (cnt !== DEPTH) begin failures++; $display("FAIL clear_length: got %0d want %0d", cnt, DEPTH); end
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'(4 * i), 32'h0, 1'b0);
      e = exp_q.pop_front();
      checks++; if (RD !== e) begin failures++; $display("FAIL cleared_word%0d: got %h want %h", i, RD, e); end
    end
  endtask

  task automatic test_byte();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h5, 32'h0000_00AB, 1'b0);
    void'(exp_q.pop_front());
    cycle();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (RD !== e || RD !== 32'h0000_AB00) begin failures++; $display("FAIL byte_word_view: got %h want 0000ab00", RD); end
    drive(1'b0, 1'b1, 2'b00, 1'b1, 32'h5, 32'h0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (RD !== e || RD !== 32'hFFFF_FFAB) begin failures++; $display("FAIL byte_signed: got %h want ffffffab", RD); end
    drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h5, 32'h0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (RD !== e || RD !== 32'h0000_00AB) begin failures++; $display("FAIL byte_unsigned: got %h want 000000ab", RD); end
  endtask

  task automatic test_half();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1122_3344, 1'b0);
    void'(exp_q.pop_front());
    cycle();
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h2, 32'h0000_8001, 1'b0);
    void'(exp_q.pop_front());
    cycle();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (RD !== e || RD !== 32'h8001_3344) begin failures++; $display("FAIL half_word_view: got %h want 80013344", RD); end
    drive(1'b0, 1'b1, 2'b01, 1'b1, 32'h2, 32'h0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (RD !== e || RD !== 32'hFFFF_8001) begin failures++; $display("FAIL half_signed: got %h want ffff8001", RD); end
    drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h0, 32'h0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (RD !== e) begin failures++; $display("FAIL half_unsigned: got %h want %h", RD, e); end
    checks++; if (Test_value !== 16'h3344) begin failures++; $display("FAIL test_value_half: got %h want 3344", Test_value); end
  endtask

  task automatic test_misaligned();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h6, 32'hDEAD_BEEF, 1'b0);
    e = exp_q.pop_front();
    checks++; if (RD !== e) begin failures++; $display("FAIL mis_load_rd: got %h want %h", RD, e); end
    cycle();
    checks++; if ({misaligned, oob_err} !== 2'b10) begin failures++; $display("FAIL mis_flag_set: got %b want 10", {misaligned, oob_err}); end
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h4, 32'h0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (RD !== e || RD !== 32'h0000_AB00) begin failures++; $display("FAIL mis_no_write: got %h want 0000ab00", RD); end
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 1'b1);
    void'(exp_q.pop_front());
    cycle();
    checks++; if (misaligned !== 1'b0) begin failures++; $display("FAIL mis_err_clr: got %b want 0", misaligned); end
    drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h1, 32'h0000_FFFF, 1'b1);
    void'(exp_q.pop_front());
    cycle();
    checks++; if (misaligned !== 1'b1) begin failures++; $display("FAIL mis_beats_clr: got %b want 1", misaligned); end
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
    e = exp_q.pop_front();
    checks++; if (RD !== e) begin failures++; $display("FAIL mis_half_no_write: got %h want %h", RD, e); end
    cycle();
  endtask

  task automatic test_oob();
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * DEPTH), 32'hFFFF_FFFF, 1'b0);
    e = exp_q.pop_front();
    checks++; if (RD !== e) begin failures++; $display("FAIL oob_rd: got %h want %h", RD, e); end
    cycle();
    checks++; if ({misaligned, oob_err} !== 2'b01) begin failures++; $display("FAIL oob_flag: got %b want 01", {misaligned, oob_err}); end
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'(4 * DEPTH - 4), 32'hCAFE_F00D, 1'b0);
    void'(exp_q.pop_front());
    cycle();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'(4 * DEPTH - 4), 32'h0, 1'b0);
    e = exp_q.pop_front();
    checks++; if (RD !== e || RD !== 32'hCAFE_F00D) begin failures++; $display("FAIL top_word: got %h want cafef00d", RD); end
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
    void'(exp_q.pop_front());
    cycle();
    drive(1'b0, 1'b1, 2'b10, 1'b0, 32'(4 * DEPTH + 1), 32'h0, 1'b0);
    void'(exp_q.pop_front());
    cycle();
    checks++; if ({misaligned, oob_err} !== 2'b11) begin failures++; $display("FAIL both_flags: got %b want 11", {misaligned, oob_err}); end
    drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1);
    void'(exp_q.pop_front());
    cycle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    logic [1:0]  sz;
    drive(1'b1, 1'b1, 2'b10, 1'b0, 32'h8, 32'h55AA_55AA, 1'b0);
    e = exp_q.pop_front();
    checks++; if (RD !== e) begin failures++; $display("FAIL rdw_old: got %h want %h", RD, e); end
    @(posedge clk);
    mstore(A, size, WD);
    #1;
    exp_q.push_back(exp_load(A, size, sign_ext));
    e = exp_q.pop_front();
    checks++; if (RD !== e) begin failures++; $display("FAIL rdw_new: got %h want %h", RD, e); end
    @(negedge clk);
    WE = 1'b0; RE = 1'b0;
    for (int i = 0; i < 24; i++) begin
      sz = 2'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 4 * DEPTH - 1));
      a  = (sz == 2'b00) ? a : (sz == 2'b01) ? (a & ~32'h1) : (a & ~32'h3);
      drive(1'b1, 1'b0, sz, 1'b0, a, $urandom, 1'b0);
      void'(exp_q.pop_front());
      cycle();
      drive(1'b0, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 4 * DEPTH + 7)), 32'h0, 1'b0);
      e = exp_q.pop_front();
      checks++; if (RD !== e) begin failures++; $display("FAIL rand_load%0d: A=%h size=%b got %h want %h", i, A, size, RD, e); end
    end
  endtask

  task automatic test_reset_mid_clear();
    int cnt;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midclear_busy: got %b want 1", busy); end
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    while (busy && cnt < 50) begin
      @(posedge clk); #1; cnt++;
    end
    checks++; if (cnt !== DEPTH) begin failures++; $display("FAIL reclear_length: got %0d want %0d", cnt, DEPTH); end
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'(4 * i), 32'h0, 1'b0);
      e = exp_q.pop_front();
      checks++; if (RD !== e) begin failures++; $display("FAIL recleared_word%0d: got %h want %h", i, RD, e); end
    end
    drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h0, 32'h1234_ABCD, 1'b0);
    void'(exp_q.pop_front());
    cycle();
    checks++; if (Test_value !== 16'hABCD) begin failures++; $display("FAIL test_value: got %h want abcd", Test_value); end
  endtask

  initial begin
    test_reset();
    test_byte();
    test_half();
    test_misaligned();
    test_oob();
    test_back_to_back();
    test_reset_mid_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
